// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared types and next-count rule for the modulo-N counter
package contador_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Worked in 32 bits so MODULUS-1 and cur+1 never overflow the count width.
  function automatic logic [31:0] next_count(
    input  logic [31:0] cur,
    input  dir_e        dir,
    input  logic [31:0] modulus,
    input  logic        saturate,
    output logic        wrap
  );
    logic [31:0] last;
    last       = modulus - 32'd1;
    wrap       = 1'b0;
    next_count = cur;
    if (dir == DIR_UP) begin
      if (cur >= last) begin
        wrap       = 1'b1;
        next_count = saturate ? last : 32'd0;
      end else begin
        next_count = cur + 32'd1;
      end
    end else begin
      if (cur == 32'd0) begin
        wrap       = 1'b1;
        next_count = saturate ? 32'd0 : last;
      end else begin
        next_count = cur - 32'd1;
      end
    end
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// rtl/prescaler_tick.sv - enable-gated tick divider, one tick per DIV_RATIO enabled cycles
module prescaler_tick #(
  parameter int DIV_RATIO = 1
) (
  input  logic clck_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int PW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV_RATIO - 1);

  logic [PW-1:0] p_q;

  always_ff @(posedge clck_i) begin
    if (rst_i) begin
      p_q <= '0;
    end else if (enable_i) begin
      p_q <= (p_q == LAST) ? '0 : p_q + 1'b1;
    end
  end

  assign tick_o = enable_i && (p_q == LAST);

endmodule

// File: rtl/contador_modulo_n.sv
// rtl/contador_modulo_n.sv - modulo-N up/down counter with prescaler, load, hold and wrap pulse
module contador_modulo_n
  import contador_pkg::*;
#(
  parameter  int MODULUS   = 4,
  parameter  int DIV_RATIO = 1,
  parameter  int SATURATE  = 0,
  localparam int W         = $clog2(MODULUS)
) (
  input  logic         clck_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         hold_i,
  input  logic         up_i,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  output logic [W-1:0] state_o,
  output logic         tick_o,
  output logic         wrap_o,
  output logic         at_limit_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count_q;
  logic         wrap_q;
  logic         tick;
  logic [W-1:0] nxt_count;
  logic         nxt_wrap;
  logic [W-1:0] load_clamped;

  prescaler_tick #(
    .DIV_RATIO(DIV_RATIO)
  ) u_prescaler (
    .clck_i  (clck_i),
    .rst_i   (rst_i),
    .enable_i(enable_i),
    .tick_o  (tick)
  );

  always_comb begin
    nxt_wrap  = 1'b0;
    nxt_count = W'(next_count(32'(count_q), dir_e'(up_i), 32'(MODULUS),
                              SATURATE != 0, nxt_wrap));
  end

  // Compared one bit wider so out-of-range loads are caught for any MODULUS.
  assign load_clamped = ({1'b0, load_value_i} > (W+1)'(MODULUS - 1)) ? LAST : load_value_i;

  always_ff @(posedge clck_i) begin
    if (rst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (load_i) begin
        count_q <= load_clamped;
      end else if (!hold_i && tick) begin
        count_q <= nxt_count;
        wrap_q  <= nxt_wrap;
      end
    end
  end

  assign state_o    = count_q;
  assign wrap_o     = wrap_q;
  assign tick_o     = tick;
  assign at_limit_o = up_i ? (count_q == LAST) : (count_q == '0);

endmodule

// File: doc/contador_modulo_n.md
# contador_modulo_n

Parametrised modulo-N up/down counter with a built-in tick prescaler, the next generation of the fixed 2-bit counter. It adds a configurable modulus, direction control, parallel load, wrap or saturate mode and a terminal-count pulse. It sits in the sequential-logic exercise datapath and replaces the separate counter plus clock-divider pair with a single clock-enable-driven block.

## Interface
- MODULUS, 4: count range 0..MODULUS-1; must be ≥2.
- DIV_RATIO, 1: prescaler ratio; count advances once per DIV_RATIO enabled cycles; must be ≥1.
- SATURATE, 0: 0 = wrap at the limits, 1 = stick at the limits.
- W (localparam), $clog2(MODULUS): width of the count.

Ports:
- clck_i  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  global enable; gates both the prescaler and the counter.
- hold_i  in  1  freezes the count; the prescaler keeps running.
- up_i  in  1  1 = count up, 0 = count down; sampled on each tick.
- load_i  in  1  parallel load request.
- load_value_i  in  W  value to load.
- state_o  out  W  current count (registered).
- tick_o  out  1  prescaler tick; combinational; high when enable_i=1 and the prescaler is at DIV_RATIO-1.
- wrap_o  out  1  registered one-cycle pulse when a tick crosses or hits a limit.
- at_limit_o  out  1  combinational; state_o equals MODULUS-1 when up_i=1, or 0 when up_i=0.

## Operation
- Prescaler: internal count p, 0..DIV_RATIO-1.
  - Advances only when enable_i=1.
  - Goes back to 0 after DIV_RATIO-1.
  - With DIV_RATIO=1, tick_o equals enable_i.
- Counter priority at each edge: rst_i > load_i > hold_i > tick_o > keep.
- Load: state_o ← load_value_i. If load_value_i ≥ MODULUS, the loaded value is clamped to MODULUS-1. Load does not touch p and does not pulse wrap_o.
- Hold: state_o is unchanged. Ticks during hold are lost, not queued. wrap_o stays 0.
- Tick, up_i=1:
  - Below MODULUS-1: increment.
  - At MODULUS-1, SATURATE=0: wrap to 0.
  - At MODULUS-1, SATURATE=1: stay at MODULUS-1.
- Tick, up_i=0:
  - Above 0: decrement.
  - At 0, SATURATE=0: wrap to MODULUS-1.
  - At 0, SATURATE=1: stay at 0.
- wrap_o: set to 1 at the edge where a tick finds the counter at its limit, in both wrap and saturate modes. Cleared at the next edge unless the same condition repeats, so it can stay high on consecutive ticks at a saturated limit.
- A direction change between ticks takes effect on the next tick; there is no extra delay.
- Arithmetic is carried out in W+1 bits before the compare, so there is no silent overflow when MODULUS is a power of two.

## Timing
- Reset: state_o=0, p=0, wrap_o=0. tick_o and at_limit_o follow from those values. Reset during a load, hold or tick wins outright.
- Latency:
  - Load → state_o: 1 cycle.
  - Tick → state_o: 1 cycle.
  - wrap_o rises in the same cycle the new count appears.
- Tick spacing: exactly DIV_RATIO enabled cycles. Cycles with enable_i=0 stretch the spacing and do not reset p.
- Load together with a tick: the load wins and the tick is dropped. p still advances.
- Hold together with a tick: the count is frozen and p still advances.

## Structure
- Package contador_pkg:
  - dir_e enum {DIR_DOWN=0, DIR_UP=1}.
  - Function next_count(cur, dir, modulus, saturate), returning the next value and a wrap flag.
- Sub-module prescaler_tick:
  - Parameter DIV_RATIO.
  - Ports clck_i, rst_i, enable_i, tick_o.
  - Reused elsewhere as the generalised clock divider.
- contador_modulo_n instantiates prescaler_tick and holds the count register and the wrap_o register.

## Test plan
Directed scenarios, all with MODULUS=10, DIV_RATIO=4, SATURATE=0 unless stated; enable_i=1 throughout unless stated.
1. Reset release, up_i=1 → ticks every 4th cycle; state_o runs 0,1,…,9,0; wrap_o is high for 1 cycle as state_o becomes 0.
2. up_i=0 from 0 → the next tick gives state_o=9 with wrap_o=1, then 8, 7, …
3. SATURATE=1, up_i=1, load 7 → state_o steps 8, 9, 9, 9; wrap_o is high on each tick at 9; at_limit_o=1 while state_o=9.
4. load_value_i=12 with load_i=1 → state_o=9 one cycle later. Load asserted in a tick cycle → loaded value kept, tick dropped.
5. hold_i=1 for 12 cycles at state_o=3 → state_o stays 3; the first tick after release gives state_o=4, with the tick phase unchanged.
6. enable_i toggled 1/0 every cycle → ticks every 8 cycles. rst_i=1 mid-count at state_o=6 → next cycle state_o=0, p=0, wrap_o=0.
